// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment reader: legal active-low patterns
// (bit6=g .. bit0=a) and the default debounce depth.
package seg_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 4;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Two BCD digits to a 0..99 binary value for step comparisons.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
        return ({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational decode of one active-low 7-segment pattern to BCD plus a
// legal flag; anything outside the ten digit shapes is illegal.
module seg7_dec
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       legal
);

    always_comb begin
        bcd   = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// Debounced two-digit seven-segment reader with step classification.
// Optional error counter enabled by defining SEG_READER_ERR_CNT_EN.
module seg_reader
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
)
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    input  logic [6:0] seg_u,
    input  logic [6:0] seg_d,
    output logic [3:0] bcd_u,
    output logic [3:0] bcd_d,
    output logic       upd,
    output logic       up_step,
    output logic       down_step,
    output logic       step_err,
    output logic       inv,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] THR = 4'(STABLE_CYCLES - 1);

    logic [13:0] sample_q, sample_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        en_q;
    logic        armed_q, armed_d;
    logic        have_prev_q, have_prev_d;
    logic [3:0]  bcd_u_q, bcd_u_d, bcd_d_q, bcd_d_d;
    logic        upd_q, upd_d, up_q, up_d, dn_q, dn_d, serr_q, serr_d, inv_q, inv_d;
    logic [3:0]  dec_u, dec_d;
    logic        leg_u, leg_d;
    logic [6:0]  cur_bin, prev_bin;
    logic        same, accept;

    seg7_dec u_dec_u (.seg(sample_q[6:0]),  .bcd(dec_u), .legal(leg_u));
    seg7_dec u_dec_d (.seg(sample_q[13:7]), .bcd(dec_d), .legal(leg_d));

    always_comb begin
        sample_d    = {seg_d, seg_u};
        same        = (sample_d == sample_q);
        // The first enabled edge after en returns counts as a fresh sample.
        cnt_d       = 4'd0;
        if (en && en_q && same)
            cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
        accept      = en && armed_q && (cnt_q >= THR);
        armed_d     = armed_q && !accept;
        if (!same)
            armed_d = 1'b1;
        cur_bin     = bcd_to_bin(dec_d, dec_u);
        prev_bin    = bcd_to_bin(bcd_d_q, bcd_u_q);
        have_prev_d = have_prev_q;
        bcd_u_d     = bcd_u_q;
        bcd_d_d     = bcd_d_q;
        upd_d       = 1'b0;
        up_d        = 1'b0;
        dn_d        = 1'b0;
        serr_d      = 1'b0;
        inv_d       = 1'b0;
        if (accept) begin
            if (!(leg_u && leg_d)) begin
                inv_d = 1'b1;
            end else if (!have_prev_q || cur_bin != prev_bin) begin
                upd_d       = 1'b1;
                bcd_u_d     = dec_u;
                bcd_d_d     = dec_d;
                have_prev_d = 1'b1;
                if (have_prev_q) begin
                    if (cur_bin == ((prev_bin == 7'd99) ? 7'd0 : prev_bin + 7'd1))
                        up_d = 1'b1;
                    else if (cur_bin == ((prev_bin == 7'd0) ? 7'd99 : prev_bin - 7'd1))
                        dn_d = 1'b1;
                    else
                        serr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sample_q    <= '0;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            armed_q     <= 1'b0;
            have_prev_q <= 1'b0;
            bcd_u_q     <= '0;
            bcd_d_q     <= '0;
            upd_q       <= 1'b0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            serr_q      <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            sample_q    <= sample_d;
            cnt_q       <= cnt_d;
            en_q        <= en;
            armed_q     <= armed_d;
            have_prev_q <= have_prev_d;
            bcd_u_q     <= bcd_u_d;
            bcd_d_q     <= bcd_d_d;
            upd_q       <= upd_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            serr_q      <= serr_d;
            inv_q       <= inv_d;
        end
    end

`ifdef SEG_READER_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_evt;

    always_comb begin
        err_evt   = serr_d | inv_d;
        err_cnt_d = err_cnt_q;
        if (err_evt && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!clr_n)
            err_cnt_q <= '0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign bcd_u     = bcd_u_q;
    assign bcd_d     = bcd_d_q;
    assign upd       = upd_q;
    assign up_step   = up_q;
    assign down_step = dn_q;
    assign step_err  = serr_q;
    assign inv       = inv_q;

endmodule

// File: tb/tb_seg_reader.sv
// Self-checking bench for seg_reader: table of held digit pairs with expected
// events queued on drive and matched (flags and cycle) when pulses appear.
module tb_seg_reader;

    localparam int S = 4;
`ifdef SEG_READER_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [4:0] EV_NONE = 5'b00000;
    localparam logic [4:0] EV_UPD  = 5'b10000;
    localparam logic [4:0] EV_UP   = 5'b11000;
    localparam logic [4:0] EV_DN   = 5'b10100;
    localparam logic [4:0] EV_SE   = 5'b10010;
    localparam logic [4:0] EV_INV  = 5'b00001;
    localparam logic [6:0] BLANK   = 7'b1111111;

    logic       clk = 1'b0;
    logic       clr_n, en;
    logic [6:0] seg_u, seg_d;
    logic [3:0] bcd_u, bcd_d;
    logic       upd, up_step, down_step, step_err, inv;
    logic [7:0] err_cnt;

    seg_reader #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .clr_n(clr_n), .en(en), .seg_u(seg_u), .seg_d(seg_d),
        .bcd_u(bcd_u), .bcd_d(bcd_d), .upd(upd), .up_step(up_step),
        .down_step(down_step), .step_err(step_err), .inv(inv), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] flags;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [6:0] d;
        logic [6:0] u;
        logic [4:0] ev;
        logic [3:0] bd;
        logic [3:0] bu;
        int         err;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vt[12];
    logic [6:0] pat[10];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         ev_seen = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [4:0] flags);
        exp_t e;
        e.flags = flags;
        e.cyc   = cyc + 1 + S;
        sb_q.push_back(e);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_bcd_u", 32'(bcd_u), 0);
        chk("rst_bcd_d", 32'(bcd_d), 0);
        chk("rst_pulses", 32'({upd, up_step, down_step, step_err, inv}), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        logic [4:0] flags;
        flags = {upd, up_step, down_step, step_err, inv};
        if (mon_en && flags != 5'b0) begin
            ev_seen++;
            if (sb_q.size() == 0) begin
                chk("unexpected_event", 32'(flags), 0);
            end else begin
                e = sb_q.pop_front();
                chk("ev_flags", 32'(flags), 32'(e.flags));
                chk("ev_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int ev0;
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;

        vt[0]  = '{pat[0], pat[1], EV_UPD,  4'd0, 4'd1, 0};
        vt[1]  = '{pat[0], pat[2], EV_UP,   4'd0, 4'd2, 0};
        vt[2]  = '{pat[0], pat[1], EV_DN,   4'd0, 4'd1, 0};
        vt[3]  = '{pat[9], pat[9], EV_SE,   4'd9, 4'd9, 1};
        vt[4]  = '{pat[0], pat[0], EV_UP,   4'd0, 4'd0, 1};
        vt[5]  = '{pat[9], pat[9], EV_DN,   4'd9, 4'd9, 1};
        vt[6]  = '{pat[0], pat[5], EV_SE,   4'd0, 4'd5, 2};
        vt[7]  = '{pat[0], pat[7], EV_SE,   4'd0, 4'd7, 3};
        vt[8]  = '{pat[0], BLANK,  EV_INV,  4'd0, 4'd7, 4};
        vt[9]  = '{pat[0], pat[7], EV_NONE, 4'd0, 4'd7, 4};
        vt[10] = '{pat[0], pat[8], EV_UP,   4'd0, 4'd8, 4};
        vt[11] = '{BLANK,  BLANK,  EV_INV,  4'd0, 4'd8, 5};

        clr_n = 1'b0;
        en    = 1'b1;
        seg_d = BLANK;
        seg_u = BLANK;
        repeat (3) @(negedge clk);
        chk_zero_outputs();
        mon_en = 1'b1;
        clr_n  = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seg_d = vt[i].d;
            seg_u = vt[i].u;
            if (vt[i].ev != EV_NONE)
                push_exp(vt[i].ev);
            repeat (6) @(negedge clk);
            chk($sformatf("vec%0d_bcd_d", i), 32'(bcd_d), 32'(vt[i].bd));
            chk($sformatf("vec%0d_bcd_u", i), 32'(bcd_u), 32'(vt[i].bu));
            chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), ERR_EN ? vt[i].err : 0);
        end

        // Units digit toggling every two cycles never settles long enough.
        ev0 = ev_seen;
        seg_d = pat[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seg_u = (i % 2 == 1) ? pat[8] : pat[9];
            @(negedge clk);
        end
        @(negedge clk);
        seg_u = pat[8];
        repeat (8) @(negedge clk);
        chk("glitch_no_event", ev_seen, ev0);
        chk("glitch_bcd_u", 32'(bcd_u), 8);

        // Disabled during a stable hold, then the full delay after re-enable.
        @(negedge clk);
        en    = 1'b0;
        seg_d = pat[1];
        seg_u = pat[2];
        repeat (8) @(negedge clk);
        chk("en0_no_event", ev_seen, ev0);
        chk("en0_bcd_d", 32'(bcd_d), 0);
        chk("en0_bcd_u", 32'(bcd_u), 8);
        @(negedge clk);
        en = 1'b1;
        push_exp(EV_SE);
        repeat (6) @(negedge clk);
        chk("en1_bcd_d", 32'(bcd_d), 1);
        chk("en1_bcd_u", 32'(bcd_u), 2);
        chk("en1_err_cnt", 32'(err_cnt), ERR_EN ? 6 : 0);

        // Reset in the middle of a pending hold.
        @(negedge clk);
        seg_d = pat[3];
        seg_u = pat[4];
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        chk_zero_outputs();
        clr_n = 1'b1;
        seg_d = pat[1];
        seg_u = pat[0];
        push_exp(EV_UPD);
        repeat (6) @(negedge clk);
        chk("post_rst_bcd_d", 32'(bcd_d), 1);
        chk("post_rst_bcd_u", 32'(bcd_u), 0);
        chk("post_rst_err_cnt", 32'(err_cnt), 0);

        repeat (4) @(negedge clk);
        chk("pending_events", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive identical samples needed to accept a pattern; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 clr_n  input  1  reset, synchronous and active-low.
REQ-004 en  input  1  enable; 0 suppresses sampling events.
REQ-005 seg_u  input  7  units-digit 7-segment bus; active-low; bit0=a..bit6=g.
REQ-006 seg_d  input  7  tens-digit 7-segment bus; same encoding.
REQ-007 bcd_u  output  4  last accepted units digit.
REQ-008 bcd_d  output  4  last accepted tens digit.
REQ-009 upd  output  1  one-cycle pulse: new valid value accepted.
REQ-010 up_step  output  1  one-cycle pulse with upd: value = previous+1 mod 100.
REQ-011 down_step  output  1  one-cycle pulse with upd: value = previous-1 mod 100.
REQ-012 step_err  output  1  one-cycle pulse with upd: value differs from previous by anything else.
REQ-013 inv  output  1  one-cycle pulse: stable pattern is not a legal digit.
REQ-014 err_cnt  output  8  saturating count of step_err plus inv events.

Function
REQ-015 Legal patterns (bit6..bit0): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; all others are illegal.
REQ-016 Both buses are registered at every edge as one 14-bit sample.
REQ-017 Stability counter: increments, saturating at 15, when the new sample equals the previous sample; clears to 0 when it differs.
REQ-018 A pattern first sampled at edge k is accepted at edge k+STABLE_CYCLES-1; event outputs are valid in the cycle after edge k+STABLE_CYCLES.
REQ-019 An accepted pattern generates exactly one event; re-arm requires a sample change.
REQ-020 If either digit is illegal, the event is inv; bcd_u, bcd_d and the previous value are unchanged.
REQ-021 If both digits are legal and value equals the last accepted value, no event is generated.
REQ-022 Otherwise upd=1, bcd outputs update on the same edge, and exactly one of up_step, down_step or step_err is set.
REQ-023 Wrap: 99->00 is up_step, 00->99 is down_step.
REQ-024 The first valid acceptance after reset asserts upd only, with no direction flag.
REQ-025 en=0: stability counter held at 0, no events, and outputs hold; after en returns to 1, the full STABLE_CYCLES delay is needed again.
REQ-026 err_cnt increments by 1 per step_err or inv pulse and saturates at 255.

Reset
REQ-027 clr_n=0 at an edge clears sample register, stability counter, armed flag, first-value flag, bcd_u=0, bcd_d=0, err_cnt=0, and all pulses to 0.
REQ-028 Reset mid-filter discards the pending pattern; the next acceptance is treated as the first one.

Configuration
REQ-029 Macro SEG_READER_ERR_CNT_EN: when defined, err_cnt is implemented per REQ-026; when undefined, err_cnt is tied to 0 and its register is absent; all other behaviour is identical.

Structure
REQ-030 Shared package seg_pkg holds the ten legal pattern constants and the STABLE_CYCLES default.
REQ-031 Sub-module seg7_dec converts one 7-bit pattern to 4-bit BCD plus a legal flag; it is purely combinational and instantiated twice.

Verification
REQ-032 Reset, then seg_d=1000000 and seg_u=1111001 ("01") held for 6 cycles -> single upd, bcd=0/1, no direction flag, pulse after edge 4.
REQ-033 From "01", present "02" and hold -> upd+up_step; then present "01" -> upd+down_step.
REQ-034 From "99", present "00" -> up_step; from "00", present "99" -> down_step.
REQ-035 From "05", present "07" -> step_err, err_cnt=1; then present seg_u=1111111 held -> inv, err_cnt=2, bcd stays 0/7.
REQ-036 Glitch: units toggles every 2 cycles for 20 cycles with STABLE_CYCLES=4 -> no events; en=0 during a stable hold -> no events.
REQ-037 Assert clr_n=0 at cycle 2 of a 4-cycle hold -> all outputs 0; the following stable "10" gives upd only, with no direction flag.
